// File: rtl/relu_ctrl.sv
// relu_ctrl: streams rows from a source buffer through a per-lane ReLU array
// (or an equal-latency bypass) into a destination buffer, one row per cycle.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 8
`endif

module relu_pe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d[W-1] ? '0 : i_d;
        end
    end

    assign o_q = r_q;
endmodule

module relu_ctrl #(
    parameter int ADDR_W = 8,
    localparam int LANES = `ARRAYWIDTH,
    localparam int LW = `OUTPUT_BUF_DATASIZE,
    localparam int DW = LANES * LW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]     rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_num;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              r_relu;
    logic [ADDR_W-1:0] r_k;
    logic              r_dcnt;

    logic              r_v1;
    logic              r_v2;
    logic [ADDR_W-1:0] r_a1;
    logic [ADDR_W-1:0] r_a2;
    logic [DW-1:0]     r_byp;

    logic              w_accept;
    logic              w_last;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_done;
    logic [DW-1:0]     w_pe;

    assign w_last = (r_k == (r_num - ADDR_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_rd_en  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (num_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_dcnt) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Config is only ever loaded from IDLE, so starts in any other state are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num  <= '0;
            r_src  <= '0;
            r_dst  <= '0;
            r_relu <= 1'b0;
            r_k    <= '0;
            r_dcnt <= 1'b0;
        end else begin
            if (w_accept) begin
                r_num  <= num_rows;
                r_src  <= src_base;
                r_dst  <= dst_base;
                r_relu <= relu_en;
                r_k    <= '0;
            end else if (r_state == S_RUN) begin
                r_k <= r_k + ADDR_W'(1);
            end
            r_dcnt <= (r_state == S_DRAIN) ? ~r_dcnt : 1'b0;
        end
    end

    // r_v1 marks rd_data valid; r_v2 marks the registered lane result valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_a1  <= '0;
            r_a2  <= '0;
            r_byp <= '0;
        end else begin
            r_v1 <= w_rd_en;
            r_a1 <= r_dst + r_k;
            r_v2 <= r_v1;
            r_a2 <= r_a1;
            if (r_v1 && !r_relu) begin
                r_byp <= rd_data;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_pe #(
            .W(LW)
        ) u_pe (
            .clk  (clk),
            .rst  (rst),
            .i_en (r_v1 & r_relu),
            .i_d  (rd_data[i*LW +: LW]),
            .o_q  (w_pe[i*LW +: LW])
        );
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign rd_en   = w_rd_en;
    assign rd_addr = w_rd_en ? (r_src + r_k) : '0;
    assign wr_en   = r_v2;
    assign wr_addr = r_v2 ? r_a2 : '0;
    assign wr_data = r_v2 ? (r_relu ? w_pe : r_byp) : '0;
endmodule

// File: tb/tb_relu_ctrl.sv
// tb_relu_ctrl: scoreboard bench for relu_ctrl with a 1-cycle read buffer model.
// Expected reads, writes and done pulses are queued at launch and checked by a monitor.
module tb_relu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_rows;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        rq[$];
    exp_t        wq[$];
    int          dq[$];
    logic [31:0] mem[256];
    logic [31:0] expd[256];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_on = 1'b0;

    relu_ctrl #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_rows (num_rows),
        .src_base (src_base),
        .dst_base (dst_base),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] relu32(input logic [31:0] v);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*8 +: 8] = v[l*8+7] ? 8'h00 : v[l*8 +: 8];
        end
        return r;
    endfunction

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_en) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", {56'd0, rd_addr}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("rd_addr", {56'd0, rd_addr}, {56'd0, e.a});
                    chk("rd_cycle", 64'(cyc), 64'(e.c));
                end
            end
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", {56'd0, wr_addr}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", {56'd0, wr_addr}, {56'd0, e.a});
                    chk("wr_data", {32'd0, wr_data}, {32'd0, e.d});
                    chk("wr_cycle", 64'(cyc), 64'(e.c));
                end
            end else if (wr_data !== 32'd0) begin
                chk("wr_data_idle", {32'd0, wr_data}, 64'd0);
            end
            if (done) begin
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                if (dq.size() == 0) begin
                    chk("done_unexpected", 64'(cyc), 64'hFFFF);
                end else begin
                    int ec;
                    ec = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int n, input logic [7:0] s, input logic [7:0] d,
                          input logic r, input int nrd, input int nwr, input bit ed);
        int   c0;
        exp_t e;
        num_rows = n[7:0];
        src_base = s;
        dst_base = d;
        relu_en  = r;
        start    = 1'b1;
        c0 = cyc;
        for (int k = 0; k < nrd; k++) begin
            e.a = s + k[7:0];
            e.d = 32'd0;
            e.c = c0 + 1 + k;
            rq.push_back(e);
        end
        for (int k = 0; k < nwr; k++) begin
            e.a = d + k[7:0];
            e.d = expd[k];
            e.c = c0 + 3 + k;
            wq.push_back(e);
        end
        if (ed) dq.push_back((n == 0) ? c0 + 1 : c0 + n + 3);
        step();
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_rows = 8'd0;
        src_base = 8'd0;
        dst_base = 8'd0;
        relu_en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        wait_cycles(2);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_addrs", {48'd0, rd_addr, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        // start together with rst must not be accepted
        step();
        start = 1'b1;
        num_rows = 8'd3;
        step();
        start = 1'b0;
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", {63'd0, busy}, 64'd0);
        wait_cycles(4);

        // basic ReLU job
        mem[10] = 32'h807F_FF01;
        mem[11] = 32'h0001_0203;
        mem[12] = 32'hFE10_8000;
        expd[0] = 32'h007F_0001;
        expd[1] = 32'h0001_0203;
        expd[2] = 32'h0010_0000;
        launch(3, 8'd10, 8'd20, 1'b1, 3, 3, 1'b1);
        wait_cycles(8);

        // bypass: unchanged data, same timing
        expd[0] = 32'h807F_FF01;
        expd[1] = 32'h0001_0203;
        expd[2] = 32'hFE10_8000;
        launch(3, 8'd10, 8'd20, 1'b0, 3, 3, 1'b1);
        wait_cycles(8);

        // zero rows
        launch(0, 8'd5, 8'd6, 1'b1, 0, 0, 1'b1);
        wait_cycles(4);

        // address wrap
        mem[8'hFE] = 32'h1122_3344;
        mem[8'hFF] = 32'h8100_7FC0;
        mem[8'h00] = 32'hFFFF_FFFF;
        expd[0] = 32'h1122_3344;
        expd[1] = 32'h0000_7F00;
        expd[2] = 32'h0000_0000;
        launch(3, 8'hFE, 8'hFF, 1'b1, 3, 3, 1'b1);
        wait_cycles(8);

        // reset mid-job, one cycle after the second read
        mem[30] = 32'h0102_0304;
        expd[0] = 32'h0102_0304;
        launch(5, 8'd30, 8'd40, 1'b1, 3, 1, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_wr_en", {63'd0, wr_en}, 64'd0);
        wait_cycles(6);
        mem[50] = 32'h7F7F_7F7F;
        mem[51] = 32'h8080_8080;
        expd[0] = 32'h7F7F_7F7F;
        expd[1] = 32'h0000_0000;
        launch(2, 8'd50, 8'd60, 1'b1, 2, 2, 1'b1);
        wait_cycles(8);

        // starts while busy and in the DONE cycle are ignored
        mem[10] = 32'h807F_FF01;
        mem[11] = 32'h0001_0203;
        mem[12] = 32'hFE10_8000;
        expd[0] = 32'h007F_0001;
        expd[1] = 32'h0001_0203;
        expd[2] = 32'h0010_0000;
        launch(3, 8'd10, 8'd20, 1'b1, 3, 3, 1'b1);
        step();
        num_rows = 8'd9;
        src_base = 8'd100;
        dst_base = 8'd200;
        relu_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cycles(3);
        num_rows = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cycles(8);

        // maximum row count, src starting at 1
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i), 8'(i * 3), 8'(255 - i), 8'(i + 128)};
        end
        for (int k = 0; k < 255; k++) expd[k] = relu32(mem[k + 1]);
        launch(255, 8'd1, 8'd0, 1'b1, 255, 255, 1'b1);
        wait_cycles(265);

        chk("rq_empty", 64'(rq.size()), 64'd0);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
